// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-input round-robin arbiter.
// The grant counters exist only when MUX2_RR_ARBITER_STATS_EN is defined.
package mux2_rr_arbiter_pkg;
    typedef logic src_t;

    localparam src_t SRC_IN0 = 1'b0;
    localparam src_t SRC_IN1 = 1'b1;

    localparam int P_CNT_NBITS = 16;
    typedef logic [P_CNT_NBITS-1:0] cnt_t;
endpackage

// File: rtl/mux2_rr_arbiter_prio.sv
// Priority register plus combinational grant/ready for two requesters.
// Priority flips to the other requester after every accepted transfer.
module mux2_rr_prio
    import mux2_rr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_vals,
    input  logic       i_can_load,
    input  logic       i_xfer,
    output logic [1:0] o_grant,
    output logic [1:0] o_rdy,
    output src_t       o_sel
);
    src_t r_prio;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_prio <= SRC_IN0;
        else if (i_xfer) r_prio <= ~o_sel;
    end

    // With no requester, sel parks on prio; the mux output is unused then.
    always_comb begin
        o_grant = 2'b00;
        o_sel   = r_prio;
        case (i_vals)
            2'b01: begin o_grant = 2'b01; o_sel = SRC_IN0; end
            2'b10: begin o_grant = 2'b10; o_sel = SRC_IN1; end
            2'b11: o_grant = r_prio ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign o_rdy = o_grant & {2{i_can_load}};
endmodule

// File: rtl/vc_mux2.sv
// Plain two-input mux used as the shared data path.
module vc_Mux2 #(
    parameter int p_nbits = 32
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               sel,
    output logic [p_nbits-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered output buffer.
// Define MUX2_RR_ARBITER_STATS_EN to add saturating per-input grant counters.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_cnt_nbits = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_val,
    output logic               in0_rdy,
    input  logic [p_nbits-1:0] in0_msg,
    input  logic               in1_val,
    output logic               in1_rdy,
    input  logic [p_nbits-1:0] in1_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_src
`ifdef MUX2_RR_ARBITER_STATS_EN
    ,
    input  logic                   clr_cnt,
    output logic [p_cnt_nbits-1:0] cnt0,
    output logic [p_cnt_nbits-1:0] cnt1
`endif
);
    logic [1:0]         w_grant;
    logic [1:0]         w_rdy;
    src_t               w_sel;
    logic               w_can_load;
    logic               w_xfer;
    logic [p_nbits-1:0] w_mux_out;

    logic               r_out_val;
    logic [p_nbits-1:0] r_out_msg;
    src_t               r_out_src;

    assign w_can_load = !r_out_val || out_rdy;
    assign w_xfer     = |w_rdy;

    mux2_rr_prio u_prio (
        .clk        (clk),
        .reset      (reset),
        .i_vals     ({in1_val, in0_val}),
        .i_can_load (w_can_load),
        .i_xfer     (w_xfer),
        .o_grant    (w_grant),
        .o_rdy      (w_rdy),
        .o_sel      (w_sel)
    );

    vc_Mux2 #(.p_nbits(p_nbits)) u_mux (
        .in0 (in0_msg),
        .in1 (in1_msg),
        .sel (w_sel),
        .out (w_mux_out)
    );

    // A load wins over a drain, giving full throughput on back-to-back traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_val <= 1'b0;
            r_out_msg <= '0;
            r_out_src <= SRC_IN0;
        end else if (w_xfer) begin
            r_out_val <= 1'b1;
            r_out_msg <= w_mux_out;
            r_out_src <= w_sel;
        end else if (r_out_val && out_rdy) begin
            r_out_val <= 1'b0;
        end
    end

    assign in0_rdy = w_rdy[0];
    assign in1_rdy = w_rdy[1];
    assign out_val = r_out_val;
    assign out_msg = r_out_msg;
    assign out_src = r_out_src;

`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [p_cnt_nbits-1:0] r_cnt0, r_cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (clr_cnt) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_rdy[0] && r_cnt0 != {p_cnt_nbits{1'b1}}) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_rdy[1] && r_cnt1 != {p_cnt_nbits{1'b1}}) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed plus random checks of mux2_rr_arbiter against a transaction-level model.
module tb_mux2_rr_arbiter;
    localparam int NB = 32;
`ifdef MUX2_RR_ARBITER_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in0_val = 1'b0, in1_val = 1'b0, out_rdy = 1'b0;
    logic [NB-1:0] in0_msg = '0, in1_msg = '0;
    logic          in0_rdy, in1_rdy, out_val, out_src;
    logic [NB-1:0] out_msg;
`ifdef MUX2_RR_ARBITER_STATS_EN
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;

    // Model: a one-slot buffer and "whose turn it is when both ask".
    bit            m_val;
    logic [NB-1:0] m_msg;
    bit            m_src;
    int            m_turn;
    int            m_cnt[2];

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.p_nbits(NB), .p_cnt_nbits(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .in0_val (in0_val),
        .in0_rdy (in0_rdy),
        .in0_msg (in0_msg),
        .in1_val (in1_val),
        .in1_rdy (in1_rdy),
        .in1_msg (in1_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src)
`ifdef MUX2_RR_ARBITER_STATS_EN
        ,
        .clr_cnt (clr_cnt),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_msg = '0; m_src = 0; m_turn = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // Drive one cycle, check against the model before the edge, then advance the model.
    task automatic cycle(input bit v0, input logic [NB-1:0] d0, input bit v1,
                         input logic [NB-1:0] d1, input bit ordy, input bit clr);
        int  g;
        bit  load;
        in0_val = v0; in0_msg = d0; in1_val = v1; in1_msg = d1; out_rdy = ordy;
`ifdef MUX2_RR_ARBITER_STATS_EN
        clr_cnt = clr;
`endif
        if (v0 && v1) g = m_turn;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        else          g = -1;
        load = (g >= 0) && (!m_val || ordy);
        @(negedge clk);
        chk("in0_rdy", in0_rdy, load && g == 0);
        chk("in1_rdy", in1_rdy, load && g == 1);
        chk("out_val", out_val, m_val);
        if (m_val) begin
            chk("out_msg", out_msg, m_msg);
            chk("out_src", out_src, m_src);
        end
`ifdef MUX2_RR_ARBITER_STATS_EN
        chk("cnt0", cnt0, m_cnt[0]);
        chk("cnt1", cnt1, m_cnt[1]);
`endif
        @(posedge clk);
        if (clr) begin
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (load && m_cnt[g] < (1 << CW) - 1) begin
            m_cnt[g] = m_cnt[g] + 1;
        end
        if (load) begin
            m_val = 1; m_msg = (g == 0) ? d0 : d1; m_src = (g == 1); m_turn = 1 - g;
        end else if (m_val && ordy) begin
            m_val = 0;
        end
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_val", out_val, 0);
        chk("rst_out_msg", out_msg, 0);
        chk("rst_out_src", out_src, 0);
        reset = 1'b0;
        #1;

        // Single requester on in1.
        cycle(0, 32'h0, 1, 32'hA5, 1, 0);
        cycle(0, 32'h0, 0, 32'h0, 0, 0);
        chk("single_msg", out_msg, 32'hA5);
        chk("single_src", out_src, 1);

        // Both valid, draining every cycle: grants must alternate starting with in0.
        for (int i = 0; i < 6; i++) begin
            chk("fair_turn", m_turn, i % 2);
            cycle(1, 32'h10 + i, 1, 32'h20 + i, 1, 0);
        end
        chk("fair_last_src", out_src, 1);
        chk("fair_last_msg", out_msg, 32'h25);

        // Backpressure with both valid: nothing accepted, buffer held.
        for (int i = 0; i < 3; i++) cycle(1, 32'h30 + i, 1, 32'h40 + i, 0, 0);
        chk("bp_hold_msg", out_msg, 32'h25);
        cycle(1, 32'h77, 1, 32'h88, 1, 0);
        chk("bp_reload_msg", out_msg, 32'h77);
        chk("bp_reload_src", out_src, 0);

        // Idle drain, then the next contended grant goes to in1.
        cycle(0, 32'h0, 0, 32'h0, 1, 0);
        chk("idle_drained", out_val, 0);
        cycle(1, 32'h51, 1, 32'h52, 1, 0);
        chk("post_idle_src", out_src, 1);

`ifdef MUX2_RR_ARBITER_STATS_EN
        cycle(0, 32'h0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 32'h60 + i, 0, 32'h0, 1, 0);
        cycle(0, 32'h0, 0, 32'h0, 1, 0);
        chk("cnt0_sat", cnt0, 3);
        cycle(1, 32'h99, 0, 32'h0, 1, 1);
        cycle(0, 32'h0, 0, 32'h0, 1, 0);
        chk("cnt0_clr", cnt0, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));

        // Mid-stream asynchronous reset with a full, stalled buffer.
        cycle(1, 32'hC0, 0, 32'h0, 0, 0);
        cycle(0, 32'h0, 0, 32'h0, 0, 0);
        chk("pre_rst_val", out_val, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_val", out_val, 0);
        chk("async_rst_msg", out_msg, 0);
        chk("async_rst_src", out_src, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cycle(1, 32'hD0, 1, 32'hD1, 1, 0);
        chk("post_rst_src", out_src, 0);
        chk("post_rst_msg", out_msg, 32'hD0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
